// File: rtl/program_loader_if.sv
// Byte-stream input and program-memory write port of the nRisc program loader.
// The loader takes the slave view; the byte source / bench takes the master view.
interface program_loader_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       prog_we;
    logic [7:0] prog_addr;
    logic [7:0] prog_data;
    logic       cpu_hold;
    logic       load_done;
    logic       load_error;
    logic [7:0] words_loaded;

    modport master (
        output in_valid, in_data,
        input  in_ready, prog_we, prog_addr, prog_data,
               cpu_hold, load_done, load_error, words_loaded
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, prog_we, prog_addr, prog_data,
               cpu_hold, load_done, load_error, words_loaded
    );
endinterface

// File: rtl/program_loader.sv
// Boot-time program loader: receives a length-framed, checksummed byte image,
// writes it into program memory and keeps the core stalled until it verifies.
module program_loader #(
    parameter logic [7:0] BASE_ADDR = 8'h00
) (
    input  logic             clock,
    input  logic             reset,
    program_loader_if.slave  bus
);

    typedef enum logic [2:0] {INIT, IDLE, LOAD, CHECK, DONE, ERROR} state_t;

    state_t     state_q, state_d;
    logic [7:0] len_q, len_d;
    logic [7:0] sum_q, sum_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] count_q, count_d;

    logic       prog_we_q, prog_we_d;
    logic [7:0] prog_addr_q, prog_addr_d;
    logic [7:0] prog_data_q, prog_data_d;
    logic       in_ready_q, in_ready_d;
    logic       cpu_hold_q, cpu_hold_d;
    logic       load_done_q, load_done_d;
    logic       load_error_q, load_error_d;

    logic       xfer;

    assign xfer = bus.in_valid && in_ready_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            len_q        <= 8'h00;
            sum_q        <= 8'h00;
            addr_q       <= BASE_ADDR;
            count_q      <= 8'h00;
            prog_we_q    <= 1'b0;
            prog_addr_q  <= BASE_ADDR;
            prog_data_q  <= 8'h00;
            in_ready_q   <= 1'b0;
            cpu_hold_q   <= 1'b1;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
        end else begin
            len_q        <= len_d;
            sum_q        <= sum_d;
            addr_q       <= addr_d;
            count_q      <= count_d;
            prog_we_q    <= prog_we_d;
            prog_addr_q  <= prog_addr_d;
            prog_data_q  <= prog_data_d;
            in_ready_q   <= in_ready_d;
            cpu_hold_q   <= cpu_hold_d;
            load_done_q  <= load_done_d;
            load_error_q <= load_error_d;
        end
    end

    // A transfer in ERROR is a fresh length byte, exactly as in IDLE.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        sum_d   = sum_q;
        addr_d  = addr_q;
        count_d = count_q;
        case (state_q)
            INIT: state_d = IDLE;
            IDLE, ERROR: begin
                if (xfer) begin
                    len_d   = bus.in_data;
                    sum_d   = 8'h00;
                    addr_d  = BASE_ADDR;
                    count_d = 8'h00;
                    state_d = (bus.in_data == 8'h00) ? CHECK : LOAD;
                end
            end
            LOAD: begin
                if (xfer) begin
                    sum_d   = sum_q + bus.in_data;
                    addr_d  = addr_q + 8'd1;
                    count_d = count_q + 8'd1;
                    if (count_q + 8'd1 == len_q) begin
                        state_d = CHECK;
                    end
                end
            end
            CHECK: begin
                if (xfer) begin
                    state_d = (bus.in_data == sum_q) ? DONE : ERROR;
                end
            end
            DONE:    state_d = DONE;
            default: state_d = INIT;
        endcase
    end

    // Status flags follow the state being entered so they change on the deciding edge.
    always_comb begin
        prog_we_d    = (state_q == LOAD) && xfer;
        prog_addr_d  = prog_we_d ? addr_q : prog_addr_q;
        prog_data_d  = prog_we_d ? bus.in_data : prog_data_q;
        in_ready_d   = (state_d != INIT) && (state_d != DONE);
        cpu_hold_d   = (state_d != DONE);
        load_done_d  = (state_d == DONE);
        load_error_d = (state_d == ERROR);
    end

    assign bus.in_ready     = in_ready_q;
    assign bus.prog_we      = prog_we_q;
    assign bus.prog_addr    = prog_addr_q;
    assign bus.prog_data    = prog_data_q;
    assign bus.cpu_hold     = cpu_hold_q;
    assign bus.load_done    = load_done_q;
    assign bus.load_error   = load_error_q;
    assign bus.words_loaded = count_q;

endmodule

// File: tb/tb_program_loader.sv
// Directed testbench for program_loader: two instances (base 00 and base FE)
// share one stimulus driver, selected by sel; writes are logged at negedges.
module tb_program_loader;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       tb_valid = 1'b0;
    logic [7:0] tb_data = 8'h00;
    logic       sel = 1'b0;

    always #5 clock = ~clock;

    program_loader_if bus0 ();
    program_loader_if bus1 ();

    assign bus0.in_valid = tb_valid && !sel;
    assign bus0.in_data  = tb_data;
    assign bus1.in_valid = tb_valid && sel;
    assign bus1.in_data  = tb_data;

    program_loader #(.BASE_ADDR(8'h00)) dut0 (.clock(clock), .reset(reset), .bus(bus0));
    program_loader #(.BASE_ADDR(8'hFE)) dut1 (.clock(clock), .reset(reset), .bus(bus1));

    logic       obs_ready, obs_we, obs_hold, obs_done, obs_err;
    logic [7:0] obs_addr, obs_data, obs_words;

    assign obs_ready = sel ? bus1.in_ready     : bus0.in_ready;
    assign obs_we    = sel ? bus1.prog_we      : bus0.prog_we;
    assign obs_addr  = sel ? bus1.prog_addr    : bus0.prog_addr;
    assign obs_data  = sel ? bus1.prog_data    : bus0.prog_data;
    assign obs_hold  = sel ? bus1.cpu_hold     : bus0.cpu_hold;
    assign obs_done  = sel ? bus1.load_done    : bus0.load_done;
    assign obs_err   = sel ? bus1.load_error   : bus0.load_error;
    assign obs_words = sel ? bus1.words_loaded : bus0.words_loaded;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] wr_addr_q[$];
    logic [7:0] wr_data_q[$];
    int         wr_cyc_q[$];

    always @(negedge clock) begin
        cyc++;
        if (obs_we === 1'b1) begin
            wr_addr_q.push_back(obs_addr);
            wr_data_q.push_back(obs_data);
            wr_cyc_q.push_back(cyc);
        end
    end

    task automatic clear_log();
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
    endtask

    // Called at a negedge; returns at the negedge following the transfer edge.
    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        tb_data  = b;
        tb_valid = 1'b1;
        while (obs_ready !== 1'b1 && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        n_checks++;
        if (obs_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL send_timeout byte=%h: in_ready=%b after %0d cycles, required 1", b, obs_ready, waited);
        end
        @(negedge clock);
        tb_valid = 1'b0;
    endtask

    task automatic do_reset(input logic s);
        tb_valid = 1'b0;
        sel = s;
        @(negedge clock);
        reset = 1'b1;
        #1;
        clear_log();
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset();
        sel = 1'b0;
        tb_valid = 1'b0;
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({obs_we, obs_addr, obs_data, obs_ready, obs_hold, obs_done, obs_err, obs_words} !==
            {1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
            n_fail++;
            $display("[TB] FAIL reset_values: got we=%b addr=%h data=%h rdy=%b hold=%b done=%b err=%b words=%h, required 0 00 00 0 1 0 0 00",
                     obs_we, obs_addr, obs_data, obs_ready, obs_hold, obs_done, obs_err, obs_words);
        end
        n_checks++;
        if (bus1.prog_addr !== 8'hFE) begin
            n_fail++;
            $display("[TB] FAIL reset_base_fe: prog_addr=%h, required fe", bus1.prog_addr);
        end
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        n_checks++;
        if (obs_ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL init_ready: in_ready=%b, required 0", obs_ready);
        end
        @(negedge clock);
        n_checks++;
        if (obs_ready !== 1'b1 || obs_hold !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL idle_ready: in_ready=%b cpu_hold=%b, required 1 1", obs_ready, obs_hold);
        end
    endtask

    task automatic test_nominal();
        logic [7:0] ea[3] = '{8'h00, 8'h01, 8'h02};
        logic [7:0] ed[3] = '{8'h11, 8'h22, 8'h33};
        clear_log();
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        n_checks++;
        if (obs_hold !== 1'b1 || obs_done !== 1'b0 || obs_words !== 8'h03) begin
            n_fail++;
            $display("[TB] FAIL nominal_pre_c: hold=%b done=%b words=%h, required 1 0 03", obs_hold, obs_done, obs_words);
        end
        send_byte(8'h66);
        n_checks++;
        if (obs_hold !== 1'b0 || obs_done !== 1'b1 || obs_ready !== 1'b0 || obs_err !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL nominal_release: hold=%b done=%b rdy=%b err=%b, required 0 1 0 0", obs_hold, obs_done, obs_ready, obs_err);
        end
        tb_data  = 8'h77;
        tb_valid = 1'b1;
        repeat (4) @(negedge clock);
        n_checks++;
        if (obs_ready !== 1'b0 || obs_done !== 1'b1 || obs_words !== 8'h03 || wr_addr_q.size() != 3) begin
            n_fail++;
            $display("[TB] FAIL done_holds: rdy=%b done=%b words=%h writes=%0d, required 0 1 03 3",
                     obs_ready, obs_done, obs_words, wr_addr_q.size());
        end
        tb_valid = 1'b0;
        n_checks++;
        if (wr_addr_q.size() != 3) begin
            n_fail++;
            $display("[TB] FAIL nominal_write_count: %0d writes, required 3", wr_addr_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (wr_addr_q[i] !== ea[i] || wr_data_q[i] !== ed[i]) begin
                    n_fail++;
                    $display("[TB] FAIL nominal_write%0d: got (%h,%h), required (%h,%h)", i, wr_addr_q[i], wr_data_q[i], ea[i], ed[i]);
                end
            end
            n_checks++;
            if (wr_cyc_q[1] != wr_cyc_q[0] + 1 || wr_cyc_q[2] != wr_cyc_q[1] + 1) begin
                n_fail++;
                $display("[TB] FAIL nominal_back_to_back: write cycles %0d %0d %0d, required consecutive",
                         wr_cyc_q[0], wr_cyc_q[1], wr_cyc_q[2]);
            end
        end
    endtask

    task automatic test_bad_retry();
        do_reset(1'b0);
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h67);
        n_checks++;
        if (obs_err !== 1'b1 || obs_hold !== 1'b1 || obs_words !== 8'h03 || obs_done !== 1'b0 || obs_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL bad_checksum: err=%b hold=%b words=%h done=%b rdy=%b, required 1 1 03 0 1",
                     obs_err, obs_hold, obs_words, obs_done, obs_ready);
        end
        clear_log();
        send_byte(8'h01);
        n_checks++;
        if (obs_err !== 1'b0 || obs_words !== 8'h00 || obs_hold !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL retry_length: err=%b words=%h hold=%b, required 0 00 1", obs_err, obs_words, obs_hold);
        end
        send_byte(8'hA5);
        send_byte(8'hA5);
        n_checks++;
        if (obs_done !== 1'b1 || obs_hold !== 1'b0 || obs_words !== 8'h01) begin
            n_fail++;
            $display("[TB] FAIL retry_done: done=%b hold=%b words=%h, required 1 0 01", obs_done, obs_hold, obs_words);
        end
        n_checks++;
        if (wr_addr_q.size() != 1) begin
            n_fail++;
            $display("[TB] FAIL retry_write_count: %0d writes, required 1", wr_addr_q.size());
        end else if (wr_addr_q[0] !== 8'h00 || wr_data_q[0] !== 8'hA5) begin
            n_fail++;
            $display("[TB] FAIL retry_write: got (%h,%h), required (00,a5)", wr_addr_q[0], wr_data_q[0]);
        end
    endtask

    task automatic test_empty();
        do_reset(1'b0);
        send_byte(8'h00);
        send_byte(8'h00);
        n_checks++;
        if (obs_done !== 1'b1 || obs_hold !== 1'b0 || wr_addr_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL empty_ok: done=%b hold=%b writes=%0d, required 1 0 0", obs_done, obs_hold, wr_addr_q.size());
        end
        do_reset(1'b0);
        send_byte(8'h00);
        send_byte(8'h01);
        n_checks++;
        if (obs_err !== 1'b1 || obs_done !== 1'b0 || obs_hold !== 1'b1 || wr_addr_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL empty_bad: err=%b done=%b hold=%b writes=%0d, required 1 0 1 0",
                     obs_err, obs_done, obs_hold, wr_addr_q.size());
        end
    endtask

    task automatic test_wrap_gaps();
        logic [7:0] frame[5] = '{8'h03, 8'h80, 8'h80, 8'h01, 8'h01};
        logic [7:0] ea[3] = '{8'hFE, 8'hFF, 8'h00};
        logic [7:0] ed[3] = '{8'h80, 8'h80, 8'h01};
        do_reset(1'b1);
        for (int i = 0; i < 5; i++) begin
            send_byte(frame[i]);
            repeat ($urandom_range(0, 3)) @(negedge clock);
        end
        n_checks++;
        if (obs_done !== 1'b1 || obs_words !== 8'h03) begin
            n_fail++;
            $display("[TB] FAIL wrap_done: done=%b words=%h, required 1 03", obs_done, obs_words);
        end
        n_checks++;
        if (wr_addr_q.size() != 3) begin
            n_fail++;
            $display("[TB] FAIL wrap_write_count: %0d writes, required 3", wr_addr_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (wr_addr_q[i] !== ea[i] || wr_data_q[i] !== ed[i]) begin
                    n_fail++;
                    $display("[TB] FAIL wrap_write%0d: got (%h,%h), required (%h,%h)", i, wr_addr_q[i], wr_data_q[i], ea[i], ed[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset(1'b0);
        send_byte(8'h04);
        send_byte(8'hAA);
        send_byte(8'hBB);
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({obs_we, obs_addr, obs_data, obs_ready, obs_hold, obs_done, obs_err, obs_words} !==
            {1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
            n_fail++;
            $display("[TB] FAIL midreset_values: got we=%b addr=%h data=%h rdy=%b hold=%b done=%b err=%b words=%h, required 0 00 00 0 1 0 0 00",
                     obs_we, obs_addr, obs_data, obs_ready, obs_hold, obs_done, obs_err, obs_words);
        end
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        n_checks++;
        if (obs_ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL midreset_init_ready: in_ready=%b, required 0", obs_ready);
        end
        @(negedge clock);
        n_checks++;
        if (obs_ready !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL midreset_idle_ready: in_ready=%b, required 1", obs_ready);
        end
        clear_log();
        send_byte(8'h02);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        n_checks++;
        if (obs_done !== 1'b1 || obs_hold !== 1'b0 || wr_addr_q.size() != 2) begin
            n_fail++;
            $display("[TB] FAIL midreset_reload: done=%b hold=%b writes=%0d, required 1 0 2", obs_done, obs_hold, wr_addr_q.size());
        end else if (wr_addr_q[0] !== 8'h00 || wr_data_q[0] !== 8'h01 ||
                     wr_addr_q[1] !== 8'h01 || wr_data_q[1] !== 8'h02) begin
            n_fail++;
            $display("[TB] FAIL midreset_writes: got (%h,%h) (%h,%h), required (00,01) (01,02)",
                     wr_addr_q[0], wr_data_q[0], wr_addr_q[1], wr_data_q[1]);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_bad_retry();
        test_empty();
        test_wrap_gaps();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/program_loader.md
# program_loader

Boot-time program loader for the nRisc core: the write side of the program memory that the core fetches from. It accepts a length-framed, checksummed byte stream over a valid/ready handshake and writes each code byte into program memory through a dedicated write port. It holds the core stalled until a complete, checksum-verified image is in memory. It sits between an external byte source (host link or test bench) and the program memory write port, alongside the core's PC fetch path.

## Interface
- BASE_ADDR, 8'h00: program memory address that receives the first code byte.
- clock  in  1  rising-edge clock, shared with the core and the program memory.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  source presents a byte on in_data.
- in_data  in  8  stream byte: a length byte, then the code bytes, then a checksum byte.
- in_ready  out  1  loader can accept a byte this cycle.
- prog_we  out  1  program memory write enable; high for exactly one cycle per write.
- prog_addr  out  8  program memory write address.
- prog_data  out  8  program memory write data.
- cpu_hold  out  1  while high, the core's PC must not advance.
- load_done  out  1  a verified image is loaded.
- load_error  out  1  the last image failed its checksum.
- words_loaded  out  8  number of code bytes written in the current attempt.

## Operation
- Frame format: L (0..255), then L code bytes, then C.
  - C = sum of the code bytes mod 256. L is not included in the sum.
- Transfer rule: a byte transfers on a rising edge only when in_valid && in_ready. Nothing else is consumed.
- Outputs: all outputs are registered.
- States and transitions:
  - INIT (reset state), in_ready=0. Goes to IDLE on the next edge, unconditionally.
  - IDLE, in_ready=1. On transfer: latch L, clear sum, set the next write address to BASE_ADDR, clear words_loaded.
    - If L==0, go to CHECK.
    - Otherwise go to LOAD.
  - LOAD, in_ready=1. On each transfer:
    - Drive prog_we=1, prog_addr=next address, prog_data=byte.
    - Add the byte to sum; increment the address (mod 256) and words_loaded.
    - After the L-th byte, go to CHECK.
  - CHECK, in_ready=1. On transfer:
    - If byte==sum, go to DONE.
    - Otherwise go to ERROR.
  - DONE, in_ready=0, cpu_hold=0, load_done=1. Terminal; only reset leaves it.
  - ERROR, in_ready=1, cpu_hold=1, load_error=1. A transfer here is treated as a new L and handled exactly as in IDLE; load_error clears on that edge.
- Arithmetic: sum, address and words_loaded are 8-bit and wrap modulo 256.
- Memory side effect: memory contents written by a failed attempt are left as-is. cpu_hold stays high, so the core never executes them.
- Reset values: prog_we=0, prog_addr=BASE_ADDR, prog_data=0, in_ready=0, cpu_hold=1, load_done=0, load_error=0, words_loaded=0, state=INIT.
- Reset mid-load: all outputs return to their reset values immediately. The partial image is abandoned and the source must resend the whole frame.

## Timing
- INIT: in_ready rises on the first edge after reset deasserts.
- Write latency: a code byte transferred at edge t produces prog_we/addr/data during cycle t..t+1. The memory captures it at edge t+1.
- No-transfer cycles: prog_we is 0 in every cycle that follows an edge without a LOAD transfer.
- Back-to-back transfers: one byte per cycle is sustained. in_valid gaps of any length insert no writes.
- Release timing: a matching C transferred at edge t drops cpu_hold and raises load_done at edge t.
  - The earliest possible C edge is one cycle after the last code byte transfer, which is the edge where the last write lands.
  - So the core never fetches an unwritten byte.
- Mismatch timing: a mismatching C raises load_error at edge t; cpu_hold remains 1.
- DONE: in_ready=0, so a held in_valid is never consumed.

## Test plan
- Nominal load: BASE_ADDR=0; send 03,11,22,33,66. Required:
  - writes (00,11), (01,22), (02,33) on successive cycles;
  - cpu_hold falls and load_done=1 on the C edge;
  - in_ready=0 afterwards, with in_valid held high and nothing consumed.
- Bad checksum then retry: send 03,11,22,33,67. Required: load_error=1, cpu_hold=1, words_loaded=3. Then send 01,A5,A5. Required:
  - load_error clears on the 01 edge;
  - one write (00,A5);
  - load_done=1.
- Empty image: send 00,00. Required: load_done=1 with no prog_we pulse. In a separate run send 00,01. Required: load_error=1.
- Gaps and wrap: BASE_ADDR=FE; send 03,80,80,01,01 with in_valid low for 0–3 random cycles between bytes. Required:
  - writes to FE, FF, 00 only, with no duplicates;
  - checksum wraps to 01 and load_done=1.
- Reset mid-frame: after 04,AA,BB, assert reset asynchronously between edges. Required:
  - all outputs take their reset values immediately;
  - in_ready=0 in the first cycle after release, 1 from the next edge;
  - a full new frame 02,01,02,03 loads correctly.
